// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, padding constants, pad-stage
// state encoding and the initial hash values used by the hash core.
package sha1_pkg;

    localparam int BLOCK_BITS  = 512;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET  = 56;   // first byte of the 64-bit length field

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        FINAL,
        EMIT,
        TAIL
    } pad_state_t;

    // SHA-1 initial hash state H0..H4
    localparam logic [31:0] SHA1_H0 = 32'h6745_2301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCD_AB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BA_DCFE;
    localparam logic [31:0] SHA1_H3 = 32'h1032_5476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2_E1F0;

    // Byte k (0 = most significant) of a 64-bit big-endian length field
    function automatic logic [7:0] len_field_byte(input logic [63:0] len, input int k);
        return len[8*(7-k) +: 8];
    endfunction

endpackage

// File: rtl/sha1_pad_block_if.sv
// Byte-stream input and 512-bit block output of the SHA-1 padding stage.
interface sha1_pad_block_if;
    import sha1_pkg::*;

    // message byte stream
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_ready;

    // padded block stream
    logic                  blk_valid;
    logic [BLOCK_BITS-1:0] blk_data;
    logic                  blk_first;
    logic                  blk_last;
    logic                  blk_ready;

    // the padding stage itself
    modport slave (
        input  in_valid, in_data, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last
    );

    // byte source / block sink driving the padding stage
    modport master (
        output in_valid, in_data, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last
    );

endinterface

// File: rtl/sha1_pad_block.sv
// SHA-1 message padding: collects a byte stream into a 64-byte buffer,
// appends 0x80, zero fill and the 64-bit big-endian bit length, and hands
// out 512-bit blocks (first byte in bits [511:504]) over valid/ready.
module sha1_pad_block
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    sha1_pad_block_if.slave   bus
);

    pad_state_t        state_reg;
    logic              in_ready_reg;
    logic              blk_valid_reg;
    logic              blk_last_reg;
    logic [6:0]        used_reg;
    logic [LEN_W-1:0]  bitlen_reg;
    logic              first_pend_reg;
    logic              len_pend_reg;
    logic              pad_owed_reg;

    logic [7:0]        buf_reg   [BLOCK_BYTES];
    logic [7:0]        lane_next [BLOCK_BYTES];

    logic [BLOCK_BITS-1:0] blk_data_flat;
    logic [63:0]           len_field;

    logic accept;
    logic fill_we;
    logic pad_we;
    logic write_len;
    logic clear_all;

    // in_ready_reg is only ever high in FILL, so it doubles as the state qualifier
    assign accept    = in_ready_reg & bus.in_valid;
    assign fill_we   = accept;
    // 0x80 lands at lane `used`: after the last byte in FINAL, or at lane 0
    // (used was cleared by the handshake) when it is still owed in TAIL
    assign pad_we    = (state_reg == FINAL) | ((state_reg == TAIL) & pad_owed_reg);
    assign write_len = ((state_reg == FINAL) & (used_reg < 7'(LEN_OFFSET))) |
                       (state_reg == TAIL);
    assign clear_all = (state_reg == EMIT) & bus.blk_ready;
    assign len_field = 64'(bitlen_reg);

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
            logic       hit;
            logic       len_we;
            logic [7:0] len_byte;

            assign hit = (used_reg == 7'(gi));

            if (gi >= LEN_OFFSET) begin : g_len
                assign len_we   = write_len;
                assign len_byte = len_field_byte(len_field, gi - LEN_OFFSET);
            end else begin : g_body
                assign len_we   = 1'b0;
                assign len_byte = 8'h00;
            end

            // Lane write decode; bytes past the pad are already zero because
            // the buffer is cleared on every block handshake.
            assign lane_next[gi] = clear_all        ? 8'h00       :
                                   (fill_we & hit)  ? bus.in_data :
                                   (pad_we & hit)   ? PAD_BYTE    :
                                   len_we           ? len_byte    :
                                                      buf_reg[gi];

            assign blk_data_flat[BLOCK_BITS-1-8*gi -: 8] = buf_reg[gi];
        end
    endgenerate

    // Block buffer: one update per lane per cycle from the decode above
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                buf_reg[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                buf_reg[i] <= lane_next[i];
            end
        end
    end

    // Control FSM with registered handshake outputs and message bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            in_ready_reg   <= 1'b1;
            blk_valid_reg  <= 1'b0;
            blk_last_reg   <= 1'b0;
            used_reg       <= 7'd0;
            bitlen_reg     <= '0;
            first_pend_reg <= 1'b1;
            len_pend_reg   <= 1'b0;
            pad_owed_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        used_reg   <= used_reg + 7'd1;
                        bitlen_reg <= bitlen_reg + LEN_W'(8);
                        if (bus.in_last) begin
                            state_reg    <= FINAL;
                            in_ready_reg <= 1'b0;
                        end else if (used_reg == 7'(BLOCK_BYTES - 1)) begin
                            state_reg     <= EMIT;
                            in_ready_reg  <= 1'b0;
                            blk_valid_reg <= 1'b1;
                            blk_last_reg  <= 1'b0;
                        end
                    end
                end

                FINAL: begin
                    // length fits only if the 0x80 left bytes 56..63 free
                    if (used_reg < 7'(LEN_OFFSET)) begin
                        blk_last_reg <= 1'b1;
                    end else begin
                        blk_last_reg <= 1'b0;
                        len_pend_reg <= 1'b1;
                        pad_owed_reg <= (used_reg == 7'(BLOCK_BYTES));
                    end
                    blk_valid_reg <= 1'b1;
                    state_reg     <= EMIT;
                end

                EMIT: begin
                    if (bus.blk_ready) begin
                        blk_valid_reg  <= 1'b0;
                        first_pend_reg <= 1'b0;
                        used_reg       <= 7'd0;
                        if (len_pend_reg) begin
                            state_reg <= TAIL;
                        end else begin
                            if (blk_last_reg) begin
                                bitlen_reg     <= '0;
                                first_pend_reg <= 1'b1;
                            end
                            state_reg    <= FILL;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end

                TAIL: begin
                    len_pend_reg  <= 1'b0;
                    pad_owed_reg  <= 1'b0;
                    blk_last_reg  <= 1'b1;
                    blk_valid_reg <= 1'b1;
                    state_reg     <= EMIT;
                end

                default: begin
                    state_reg    <= FILL;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.blk_valid = blk_valid_reg;
    assign bus.blk_data  = blk_data_flat;
    assign bus.blk_first = blk_valid_reg & first_pend_reg;
    assign bus.blk_last  = blk_last_reg;

endmodule
